// File: rtl/apb_completer_regfile.sv
// APB4 completer with a bank of byte-strobed registers, programmable wait states,
// range/security error reporting and requester protocol-violation detection.
module apb_completer_regfile #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int NUM_REGS    = 16,
    parameter int SECURE_REGS = 0
) (
    input  logic                           pclk,
    input  logic                           preset,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic [2:0]                     pprot,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    input  logic [DATA_WIDTH/8-1:0]        pstrb,
    input  logic [3:0]                     wait_cycles,
    output logic                           pready,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pslverr,
    output logic                           proto_err,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       strb_q, strb_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic                    proto_err_q, proto_err_d;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];

    logic [31:0]             idx_full;
    logic [IDX_W-1:0]        idx_sel;
    logic                    nonsecure;
    logic                    setup_err;
    logic                    commit;

    assign idx_full  = 32'(paddr >> LSB);
    assign idx_sel   = idx_full[IDX_W-1:0];
    assign nonsecure = (pprot & 3'b010) != 3'b000;
    assign setup_err = (idx_full >= 32'(NUM_REGS)) ||
                       ((idx_full < 32'(SECURE_REGS)) && nonsecure);

    // Outputs depend only on flops, so there is no input-to-output path.
    assign pready    = (state_q == ACCESS) && (cnt_q == 4'd0);
    assign pslverr   = pready && err_q;
    assign prdata    = prdata_q;
    assign proto_err = proto_err_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        err_d       = err_q;
        prdata_d    = prdata_q;
        proto_err_d = 1'b0;
        commit      = 1'b0;
        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    state_d  = ACCESS;
                    cnt_d    = wait_cycles;
                    idx_d    = idx_sel;
                    write_d  = pwrite;
                    wdata_d  = pwdata;
                    strb_d   = pstrb;
                    err_d    = setup_err;
                    prdata_d = (!pwrite && !setup_err) ? regs_q[idx_sel] : '0;
                end else if (psel && penable) begin
                    proto_err_d = 1'b1;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_d     = IDLE;
                    proto_err_d = 1'b1;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (penable) begin
                    state_d = IDLE;
                    commit  = write_q && !err_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        for (int b = 0; b < STRB_W; b++) begin
            if (commit && strb_q[b]) begin
                regs_d[idx_q][b*8 +: 8] = wdata_q[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            strb_q      <= '0;
            err_q       <= 1'b0;
            prdata_q    <= '0;
            proto_err_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            err_q       <= err_d;
            prdata_q    <= prdata_d;
            proto_err_q <= proto_err_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_o
            assign regs_o[gi*DATA_WIDTH +: DATA_WIDTH] = regs_q[gi];
        end
    endgenerate
endmodule

// File: tb/tb_apb_completer_regfile.sv
// Directed bench for apb_completer_regfile: transfers, strobes, wait states,
// errors, protocol aborts and reset, all with hand-computed expectations.
module tb_apb_completer_regfile;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NR = 16;
    localparam int SR = 2;

    logic          pclk = 1'b0;
    logic          preset;
    logic [AW-1:0] paddr;
    logic [2:0]    pprot;
    logic          psel, penable, pwrite;
    logic [DW-1:0] pwdata;
    logic [3:0]    pstrb;
    logic [3:0]    wait_cycles;
    logic          pready;
    logic [DW-1:0] prdata;
    logic          pslverr;
    logic          proto_err;
    logic [NR*DW-1:0] regs_o;

    int vectors = 0;
    int miscompares = 0;
    logic [DW-1:0] exp_regs [NR];

    apb_completer_regfile #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .SECURE_REGS(SR)
    ) dut (
        .pclk(pclk), .preset(preset), .paddr(paddr), .pprot(pprot),
        .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .pstrb(pstrb), .wait_cycles(wait_cycles), .pready(pready),
        .prdata(prdata), .pslverr(pslverr), .proto_err(proto_err),
        .regs_o(regs_o)
    );

    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NR; i++) begin
            check($sformatf("%s_reg%0d", tag, i), regs_o[i*DW +: DW], exp_regs[i]);
        end
    endtask

    task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic [3:0] strb, input logic [2:0] prot, input logic [3:0] waits,
                        output logic [DW-1:0] rdata, output logic err, output int nwait);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        pstrb = strb; pprot = prot; wait_cycles = waits;
        step();
        penable = 1'b1;
        nwait = 0;
        while (pready !== 1'b1 && nwait < 20) begin
            check("pslverr_low_while_waiting", {31'd0, pslverr}, 32'd0);
            nwait++;
            step();
        end
        rdata = prdata;
        err = pslverr;
        step();
        psel = 1'b0; penable = 1'b0;
        $display("xfer wr=%0b addr=%h wdata=%h strb=%h prot=%0d waits=%0d -> rdata=%h err=%0b nwait=%0d",
                 wr, addr, data, strb, prot, waits, rdata, err, nwait);
    endtask

    initial begin
        logic [DW-1:0] rd;
        logic          er;
        int            nw;

        preset = 1'b1; paddr = '0; pprot = '0; psel = 1'b0; penable = 1'b0;
        pwrite = 1'b0; pwdata = '0; pstrb = '0; wait_cycles = '0;
        for (int i = 0; i < NR; i++) exp_regs[i] = '0;
        repeat (3) step();
        check("rst_pready", {31'd0, pready}, 32'd0);
        check("rst_pslverr", {31'd0, pslverr}, 32'd0);
        check("rst_prdata", prdata, 32'd0);
        check("rst_proto_err", {31'd0, proto_err}, 32'd0);
        check_regs("rst");
        preset = 1'b0;
        step();

        // Zero-wait write then read back
        xfer(1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 3'b000, 4'd0, rd, er, nw);
        exp_regs[2] = 32'hDEADBEEF;
        check("w0_nwait", 32'(nw), 32'd0);
        check("w0_err", {31'd0, er}, 32'd0);
        check("w0_reg2", regs_o[2*DW +: DW], 32'hDEADBEEF);
        xfer(1'b0, 32'h08, 32'h0, 4'h0, 3'b000, 4'd0, rd, er, nw);
        check("r0_nwait", 32'(nw), 32'd0);
        check("r0_rdata", rd, 32'hDEADBEEF);
        check("r0_err", {31'd0, er}, 32'd0);
        check("r0_prdata_hold", prdata, 32'hDEADBEEF);

        // Byte strobes on reg1
        xfer(1'b1, 32'h04, 32'h11223344, 4'hF, 3'b000, 4'd0, rd, er, nw);
        xfer(1'b1, 32'h04, 32'hAABBCCDD, 4'b0101, 3'b000, 4'd0, rd, er, nw);
        exp_regs[1] = 32'h11BB33DD;
        check("strb_reg1", regs_o[1*DW +: DW], 32'h11BB33DD);
        xfer(1'b1, 32'h05, 32'hFFFFFFFF, 4'h0, 3'b000, 4'd0, rd, er, nw);
        check("strb0_err", {31'd0, er}, 32'd0);
        check_regs("strb");

        // Three wait states on a read of reg0
        xfer(1'b0, 32'h00, 32'h0, 4'h0, 3'b000, 4'd3, rd, er, nw);
        check("wait3_nwait", 32'(nw), 32'd3);
        check("wait3_rdata", rd, 32'd0);

        // Out-of-range write
        xfer(1'b1, 32'h40, 32'h12345678, 4'hF, 3'b000, 4'd1, rd, er, nw);
        check("oor_err", {31'd0, er}, 32'd1);
        check("oor_nwait", 32'(nw), 32'd1);
        check_regs("oor");

        // Security: non-secure read of a secure register, then secure read
        xfer(1'b0, 32'h04, 32'h0, 4'h0, 3'b010, 4'd0, rd, er, nw);
        check("sec_ns_err", {31'd0, er}, 32'd1);
        check("sec_ns_rdata", rd, 32'd0);
        xfer(1'b0, 32'h04, 32'h0, 4'h0, 3'b000, 4'd0, rd, er, nw);
        check("sec_s_err", {31'd0, er}, 32'd0);
        check("sec_s_rdata", rd, 32'h11BB33DD);
        xfer(1'b1, 32'h0C, 32'hA5A5A5A5, 4'hF, 3'b010, 4'd0, rd, er, nw);
        exp_regs[3] = 32'hA5A5A5A5;
        check("ns_ok_err", {31'd0, er}, 32'd0);

        // Protocol abort: psel drops during a 2-wait write to reg4
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h55667788;
        pstrb = 4'hF; pprot = 3'b000; wait_cycles = 4'd2;
        step();
        penable = 1'b1;
        step();
        check("abort_pready_mid", {31'd0, pready}, 32'd0);
        psel = 1'b0; penable = 1'b0;
        step();
        $display("abort: psel dropped, proto_err=%0b pready=%0b", proto_err, pready);
        check("abort_proto_err", {31'd0, proto_err}, 32'd1);
        check("abort_pready", {31'd0, pready}, 32'd0);
        step();
        check("abort_proto_err_clear", {31'd0, proto_err}, 32'd0);
        check_regs("abort");
        xfer(1'b1, 32'h10, 32'h00000055, 4'b0001, 3'b000, 4'd0, rd, er, nw);
        exp_regs[4] = 32'h00000055;
        check("post_abort_err", {31'd0, er}, 32'd0);
        check("post_abort_reg4", regs_o[4*DW +: DW], 32'h00000055);

        // penable high with psel in IDLE is ignored
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h14; pwdata = 32'hFFFF0000;
        step();
        $display("idle penable: proto_err=%0b pready=%0b", proto_err, pready);
        check("idle_pen_proto_err", {31'd0, proto_err}, 32'd1);
        check("idle_pen_pready", {31'd0, pready}, 32'd0);
        psel = 1'b0; penable = 1'b0;
        step();
        check("idle_pen_proto_clear", {31'd0, proto_err}, 32'd0);
        check_regs("idle_pen");

        // Reset during the access phase of a write
        xfer(1'b0, 32'h08, 32'h0, 4'h0, 3'b000, 4'd0, rd, er, nw);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h18; pwdata = 32'hCAFEF00D;
        pstrb = 4'hF; wait_cycles = 4'd0;
        step();
        penable = 1'b1;
        check("rstmid_pready_before", {31'd0, pready}, 32'd1);
        preset = 1'b1;
        step();
        psel = 1'b0; penable = 1'b0;
        $display("reset mid-transfer: pready=%0b prdata=%h pslverr=%0b", pready, prdata, pslverr);
        for (int i = 0; i < NR; i++) exp_regs[i] = '0;
        check("rstmid_pready", {31'd0, pready}, 32'd0);
        check("rstmid_pslverr", {31'd0, pslverr}, 32'd0);
        check("rstmid_prdata", prdata, 32'd0);
        check("rstmid_proto_err", {31'd0, proto_err}, 32'd0);
        check_regs("rstmid");
        preset = 1'b0;
        step();
        check("rstmid_idle", {31'd0, pready}, 32'd0);
        xfer(1'b0, 32'h18, 32'h0, 4'h0, 3'b000, 4'd0, rd, er, nw);
        check("rstmid_lost_rdata", rd, 32'd0);
        check("rstmid_lost_nwait", 32'(nw), 32'd0);
        check_regs("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/apb_completer_regfile.md
# apb_completer_regfile

APB4 completer (responder) RTL that terminates the bus driven by the agent's requester side. It holds a bank of NUM_REGS DATA_WIDTH-bit registers, services reads and writes with a per-transfer programmable wait-state count, and honours byte strobes. It flags out-of-range and protection violations on pslverr. It is the DUT-side counterpart used to exercise the requester driver and monitor end-to-end, and can be reused as a simple peripheral register bank.

## Interface
Reset is synchronous and active-high.

- DATA_WIDTH, 32: data width; must be 8, 16 or 32
- ADDR_WIDTH, 32: address width; must be 32 or less
- NUM_REGS, 16: register count; must be 1 to 256
- SECURE_REGS, 0: registers at indices 0 to SECURE_REGS-1 are secure-only

Ports:

- pclk, in, 1: bus clock; all logic is on the rising edge
- preset, in, 1: synchronous, active-high reset
- paddr, in, ADDR_WIDTH: byte address
- pprot, in, 3: protection type; bit 1 = non-secure
- psel, in, 1: select
- penable, in, 1: enable
- pwrite, in, 1: 1 = write
- pwdata, in, DATA_WIDTH: write data
- pstrb, in, DATA_WIDTH/8: write byte strobes
- wait_cycles, in, 4: number of wait states inserted in the transfer; sampled in the setup phase
- pready, out, 1: completer ready
- prdata, out, DATA_WIDTH: read data
- pslverr, out, 1: transfer error; meaningful only while pready is high
- proto_err, out, 1: one-cycle pulse on a requester protocol violation
- regs_o, out, NUM_REGS*DATA_WIDTH: flattened register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]

## Operation

**State machine: IDLE and ACCESS.**
- IDLE with psel=1 and penable=0 (setup phase) → ACCESS. On that edge the block:
  - loads the wait counter from wait_cycles;
  - latches the register index, pwrite, pwdata and pstrb;
  - latches the error flag;
  - for a non-error read, latches prdata = reg[idx]; otherwise prdata = 0.
- ACCESS with counter > 0: decrement the counter and hold pready=0.
- ACCESS with counter = 0: pready=1. On that edge (psel, penable and pready all high):
  - a non-error write is committed;
  - the state returns to IDLE.
- Back-to-back transfers: the next setup phase is accepted in the IDLE cycle that follows. Sustained throughput is therefore one transfer per 2+wait_cycles cycles.

**Decode.**
- idx = paddr >> log2(DATA_WIDTH/8). The low byte-offset bits are ignored.
- Error if idx ≥ NUM_REGS.
- Error if idx < SECURE_REGS and pprot[1]=1.
- An error transfer completes normally with pslverr=1 and prdata=0, and writes nothing.

**Writes.** For each byte lane b with pstrb[b]=1, reg[idx] byte b takes pwdata byte b. Lanes with pstrb[b]=0 are unchanged. pstrb=0 gives a successful transfer with no update.

**Reads.** pstrb is ignored. The read value is the register content at the setup edge.

**Protocol violations.**
- psel falls while in ACCESS: abort and return to IDLE. No write occurs. proto_err pulses for one cycle.
- penable=1 with psel=1 while in IDLE: ignored, state stays IDLE, proto_err pulses.
- Address or control changing during ACCESS is not checked; the latched values are used.

**Reset.**
- preset=1 forces IDLE.
- All outputs reset as follows: pready=0, pslverr=0, prdata=0, proto_err=0. All registers (and therefore regs_o) reset to 0.
- Reset asserted mid-transfer aborts the transfer and discards any pending write.

## Timing
- pready and pslverr are decoded combinationally from the registered state and counter; no input-to-output combinational path exists.
- pslverr=0 whenever pready=0.
- prdata holds its value after completion until the next setup phase.
- Zero wait states: setup at cycle N, access with pready=1 at N+1, write visible on regs_o at N+2.
- k wait states: pready is low for k cycles, then high for one cycle.

## Test plan
- **Zero-wait write then read.** With wait_cycles=0: write 0xDEADBEEF to addr 0x08 with pstrb=0xF, then read 0x08. Required: pready high at the first access cycle of each transfer, prdata=0xDEADBEEF, pslverr=0, reg2 on regs_o = 0xDEADBEEF.
- **Byte strobes.** reg1 holds 0x11223344. Write 0xAABBCCDD to addr 0x04 with pstrb=0b0101. Required: reg1 = 0x11BB33DD.
- **Wait states.** With wait_cycles=3: read reg0. Required: pready low for exactly 3 access cycles and high on the 4th; total transfer length 5 cycles.
- **Errors.** With NUM_REGS=16 and SECURE_REGS=2:
  - write to addr 0x40 → pslverr=1 on the completion cycle, no register changes;
  - read of addr 0x04 with pprot=3'b010 → pslverr=1, prdata=0;
  - same read with pprot=3'b000 → pslverr=0.
- **Protocol abort.** Drop psel during a 2-wait write. Required: proto_err pulses once, the register is unchanged, and the next valid transfer completes normally.
- **Reset mid-transfer.** Assert preset during the access phase of a write. Required: next cycle all outputs are 0, all registers are 0, state is IDLE, and the write is lost.
